// File: rtl/pc8e_pkg.sv
// Shared types and constants for the PC8E-style high-speed paper-tape reader.
package pc8e_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } fetch_state_e;

    // Bit positions of the IOP pulses in the {iop_4, iop_2, iop_1} vector
    localparam int unsigned IopRsf = 0;
    localparam int unsigned IopRrb = 1;
    localparam int unsigned IopRfc = 2;

    localparam logic [5:0] DevCodeDefault = 6'o01;

endpackage

// File: rtl/pc8e_reader_if.sv
// PDP-8/I positive I/O bus signals seen by the tape reader; master is the CPU side.
interface pc8e_reader_if;

    logic        iop_1;
    logic        iop_2;
    logic        iop_4;
    logic        i_o_pwr_clr;
    logic [11:0] io_bmb;
    logic [11:0] db_l;
    logic        i_o_data_in;
    logic        i_o_skp_rq_l;
    logic        i_o_int_rq_l;

    modport master (
        output iop_1, iop_2, iop_4, i_o_pwr_clr, io_bmb,
        input  db_l, i_o_data_in, i_o_skp_rq_l, i_o_int_rq_l
    );

    modport slave (
        input  iop_1, iop_2, iop_4, i_o_pwr_clr, io_bmb,
        output db_l, i_o_data_in, i_o_skp_rq_l, i_o_int_rq_l
    );

endinterface

// File: rtl/pc8e_reader_iop_edge.sv
// Rising-edge detector for the three IOP pulse levels; synchronous active-low reset.
module iop_edge (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] iop,
    output logic [2:0] rise
);

    logic [2:0] iop_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            iop_q <= '0;
        end else begin
            iop_q <= iop;
        end
    end

    assign rise = iop & ~iop_q;

endmodule

// File: rtl/pc8e_reader.sv
// PC8E-style paper-tape reader responder on the PDP-8/I I/O bus.
// Define PC8E_INT_EN to drive a registered interrupt request from the reader flag.
module pc8e_reader
    import pc8e_pkg::*;
#(
    parameter logic [5:0]  DEV_CODE     = DevCodeDefault,
    parameter int unsigned FETCH_CYCLES = 1000,
    parameter int unsigned CW           = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pc8e_reader_if.slave         bus,
    output logic                 tape_req,
    input  logic [7:0]           tape_data,
    input  logic                 tape_strobe,
    output logic                 flag,
    output logic                 busy
);

    localparam logic [CW-1:0] CntLoad = CW'(FETCH_CYCLES - 1);

    fetch_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    rb_q, rb_d;
    logic          flag_q, flag_d;

    logic       clr_n;
    logic       sel;
    logic [2:0] rise;
    logic       rrb_fire;
    logic       fetch_start;
    logic       strobe_take;
    logic       fetch_done;
    logic       rsf_active;
    logic       rrb_active;

    // Power clear is indistinguishable from reset
    assign clr_n = rst & ~bus.i_o_pwr_clr;
    assign sel   = (bus.io_bmb[8:3] == DEV_CODE);

    iop_edge u_iop_edge (
        .clk  (clk),
        .rst  (clr_n),
        .iop  ({bus.iop_4, bus.iop_2, bus.iop_1}),
        .rise (rise)
    );

    assign rrb_fire    = rise[IopRrb] & sel;
    // RFC only acts from idle; while busy it neither restarts nor clears the flag
    assign fetch_start = rise[IopRfc] & sel & (state_q == StIdle);
    assign strobe_take = (state_q == StReq) & tape_strobe;
    assign fetch_done  = (state_q == StWait) & (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (fetch_start) state_d = StReq;
            StReq:  if (tape_strobe) state_d = StWait;
            StWait: if (cnt_q == '0) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tape_req = (state_q == StReq);
        busy     = (state_q != StIdle);
    end

    always_comb begin
        cnt_d = cnt_q;
        rb_d  = rb_q;
        if (strobe_take) begin
            rb_d  = tape_data;
            cnt_d = CntLoad;
        end else if ((state_q == StWait) && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Set after clear so a completing fetch wins over a same-cycle clear
    always_comb begin
        flag_d = flag_q;
        if (rrb_fire || fetch_start) flag_d = 1'b0;
        if (fetch_done)              flag_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            cnt_q  <= '0;
            rb_q   <= '0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            rb_q   <= rb_d;
            flag_q <= flag_d;
        end
    end

    assign flag = flag_q;

    assign rsf_active       = bus.iop_1 & sel & flag_q;
    assign rrb_active       = bus.iop_2 & sel;
    assign bus.i_o_skp_rq_l = ~rsf_active;
    assign bus.i_o_data_in  = ~rrb_active;
    assign bus.db_l         = rrb_active ? ~{4'b0000, rb_q} : 12'o7777;

`ifdef PC8E_INT_EN
    logic int_q;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            int_q <= 1'b1;
        end else begin
            int_q <= ~flag_q;
        end
    end

    assign bus.i_o_int_rq_l = int_q;
`else
    assign bus.i_o_int_rq_l = 1'b1;
`endif

    logic unused_bmb;
    assign unused_bmb = ^{bus.io_bmb[11:9], bus.io_bmb[2:0]};

endmodule

// File: tb/tb_pc8e_reader.sv
// Self-checking bench for pc8e_reader with a tape-byte scoreboard (FETCH_CYCLES = 4).
module tb_pc8e_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       tape_req;
    logic [7:0] tape_data;
    logic       tape_strobe;
    logic       flag;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0]  sb[$];
    logic [7:0]  exp_byte;
    logic [11:0] exp_db;

    always #5 clk = ~clk;

    pc8e_reader_if bus ();

    pc8e_reader #(
        .FETCH_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .tape_req    (tape_req),
        .tape_data   (tape_data),
        .tape_strobe (tape_strobe),
        .flag        (flag),
        .busy        (busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle;
        bus.iop_1  = 1'b0;
        bus.iop_2  = 1'b0;
        bus.iop_4  = 1'b0;
        bus.io_bmb = 12'o0000;
    endtask

    task automatic pop_expected;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: got 0 entries, required at least 1");
            exp_db = 12'o7777;
        end else begin
            exp_byte = sb.pop_front();
            exp_db   = ~{4'b0000, exp_byte};
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus.i_o_pwr_clr = 1'b0;
        bus_idle();
        tape_strobe = 1'b0;
        tape_data   = 8'h00;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        n_checks++; if (flag !== 1'b0) begin n_fail++; $display("FAIL reset_flag: got %b required 0", flag); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_checks++; if (tape_req !== 1'b0) begin n_fail++; $display("FAIL reset_tape_req: got %b required 0", tape_req); end
        n_checks++; if (bus.db_l !== 12'o7777) begin n_fail++; $display("FAIL reset_db_l: got %o required 7777", bus.db_l); end
        n_checks++; if (bus.i_o_data_in !== 1'b1) begin n_fail++; $display("FAIL reset_data_in: got %b required 1", bus.i_o_data_in); end
        n_checks++; if (bus.i_o_skp_rq_l !== 1'b1) begin n_fail++; $display("FAIL reset_skp: got %b required 1", bus.i_o_skp_rq_l); end
        n_checks++; if (bus.i_o_int_rq_l !== 1'b1) begin n_fail++; $display("FAIL reset_int: got %b required 1", bus.i_o_int_rq_l); end
    endtask

    task automatic test_fetch;
        bus.io_bmb = 12'o6014;
        bus.iop_4  = 1'b1;
        #1;
        n_checks++; if (tape_req !== 1'b0) begin n_fail++; $display("FAIL rfc_req_early: got %b required 0", tape_req); end
        tick();
        n_checks++; if (tape_req !== 1'b1) begin n_fail++; $display("FAIL rfc_req_latency: got %b required 1", tape_req); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rfc_busy: got %b required 1", busy); end
        bus_idle();
        tape_data   = 8'o215;
        tape_strobe = 1'b1;
        sb.push_back(8'o215);
        tick();
        tape_strobe = 1'b0;
        repeat (3) tick();
        n_checks++; if (flag !== 1'b0) begin n_fail++; $display("FAIL flag_early: got %b required 0", flag); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wait_busy: got %b required 1", busy); end
        tick();
        n_checks++; if (flag !== 1'b1) begin n_fail++; $display("FAIL flag_on_time: got %b required 1", flag); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL done_busy: got %b required 0", busy); end
        n_checks++; if (bus.i_o_int_rq_l !== 1'b1) begin n_fail++; $display("FAIL int_same_edge: got %b required 1", bus.i_o_int_rq_l); end
        tick();
`ifdef PC8E_INT_EN
        n_checks++; if (bus.i_o_int_rq_l !== 1'b0) begin n_fail++; $display("FAIL int_asserted: got %b required 0", bus.i_o_int_rq_l); end
`else
        n_checks++; if (bus.i_o_int_rq_l !== 1'b1) begin n_fail++; $display("FAIL int_polled: got %b required 1", bus.i_o_int_rq_l); end
`endif
    endtask

    task automatic test_skip;
        bus.io_bmb = 12'o6011;
        bus.iop_1  = 1'b1;
        #1;
        n_checks++; if (bus.i_o_skp_rq_l !== 1'b0) begin n_fail++; $display("FAIL rsf_skip: got %b required 0", bus.i_o_skp_rq_l); end
        bus.iop_1 = 1'b0;
        #1;
        n_checks++; if (bus.i_o_skp_rq_l !== 1'b1) begin n_fail++; $display("FAIL rsf_release: got %b required 1", bus.i_o_skp_rq_l); end
        bus.io_bmb = 12'o6021;
        bus.iop_1  = 1'b1;
        #1;
        n_checks++; if (bus.i_o_skp_rq_l !== 1'b1) begin n_fail++; $display("FAIL rsf_wrong_dev: got %b required 1", bus.i_o_skp_rq_l); end
        bus_idle();
        tick();
    endtask

    task automatic test_wrong_dev;
        bus.io_bmb = 12'o6022;
        bus.iop_2  = 1'b1;
        #1;
        n_checks++; if (bus.db_l !== 12'o7777) begin n_fail++; $display("FAIL dev2_db_l: got %o required 7777", bus.db_l); end
        n_checks++; if (bus.i_o_data_in !== 1'b1) begin n_fail++; $display("FAIL dev2_data_in: got %b required 1", bus.i_o_data_in); end
        tick();
        bus.iop_2  = 1'b0;
        bus.io_bmb = 12'o6024;
        bus.iop_4  = 1'b1;
        tick();
        bus_idle();
        tick();
        n_checks++; if (tape_req !== 1'b0) begin n_fail++; $display("FAIL dev2_no_fetch: got %b required 0", tape_req); end
        n_checks++; if (flag !== 1'b1) begin n_fail++; $display("FAIL dev2_flag_kept: got %b required 1", flag); end
    endtask

    task automatic test_read_and_fetch;
        bus.io_bmb = 12'o6016;
        bus.iop_2  = 1'b1;
        #1;
        pop_expected();
        n_checks++; if (bus.db_l !== exp_db) begin n_fail++; $display("FAIL rrb_db_l: got %o required %o", bus.db_l, exp_db); end
        n_checks++; if (bus.i_o_data_in !== 1'b0) begin n_fail++; $display("FAIL rrb_data_in: got %b required 0", bus.i_o_data_in); end
        tick();
        bus.iop_2 = 1'b0;
        #1;
        n_checks++; if (flag !== 1'b0) begin n_fail++; $display("FAIL rrb_flag_clr: got %b required 0", flag); end
        n_checks++; if (bus.db_l !== 12'o7777) begin n_fail++; $display("FAIL rrb_db_release: got %o required 7777", bus.db_l); end
        bus.iop_4 = 1'b1;
        tick();
        n_checks++; if (tape_req !== 1'b1) begin n_fail++; $display("FAIL 6016_req: got %b required 1", tape_req); end
        bus_idle();
        bus.io_bmb = 12'o6011;
        bus.iop_1  = 1'b1;
        #1;
        n_checks++; if (bus.i_o_skp_rq_l !== 1'b1) begin n_fail++; $display("FAIL rsf_no_flag: got %b required 1", bus.i_o_skp_rq_l); end
        bus_idle();
        tape_data   = 8'o142;
        tape_strobe = 1'b1;
        sb.push_back(8'o142);
        tick();
        tape_strobe = 1'b0;
        repeat (4) tick();
        n_checks++; if (flag !== 1'b1) begin n_fail++; $display("FAIL second_flag: got %b required 1", flag); end
        bus.io_bmb = 12'o6012;
        bus.iop_2  = 1'b1;
        #1;
        pop_expected();
        n_checks++; if (bus.db_l !== exp_db) begin n_fail++; $display("FAIL second_read: got %o required %o", bus.db_l, exp_db); end
        tick();
        bus_idle();
        #1;
        n_checks++; if (flag !== 1'b0) begin n_fail++; $display("FAIL second_clr: got %b required 0", flag); end
    endtask

    task automatic test_busy_rfc;
        bus.io_bmb = 12'o6014;
        bus.iop_4  = 1'b1;
        tick();
        bus.iop_4 = 1'b0;
        tick();
        bus.iop_4 = 1'b1;
        tick();
        bus.iop_4 = 1'b0;
        n_checks++; if (tape_req !== 1'b1) begin n_fail++; $display("FAIL req_hold: got %b required 1", tape_req); end
        tape_data   = 8'o377;
        tape_strobe = 1'b1;
        sb.push_back(8'o377);
        tick();
        tape_strobe = 1'b0;
        tick();
        bus.iop_4 = 1'b1;
        tick();
        bus.iop_4 = 1'b0;
        n_checks++; if (tape_req !== 1'b0) begin n_fail++; $display("FAIL rfc_in_wait: got %b required 0", tape_req); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rfc_wait_busy: got %b required 1", busy); end
        tick();
        n_checks++; if (flag !== 1'b0) begin n_fail++; $display("FAIL busy_flag_early: got %b required 0", flag); end
        tick();
        n_checks++; if (flag !== 1'b1) begin n_fail++; $display("FAIL busy_flag_time: got %b required 1", flag); end
        bus.io_bmb = 12'o6012;
        bus.iop_2  = 1'b1;
        #1;
        pop_expected();
        n_checks++; if (bus.db_l !== exp_db) begin n_fail++; $display("FAIL busy_read: got %o required %o", bus.db_l, exp_db); end
        tick();
        bus_idle();
        tick();
    endtask

    task automatic test_set_wins;
        bus.io_bmb = 12'o6014;
        bus.iop_4  = 1'b1;
        tick();
        bus_idle();
        tape_data   = 8'o052;
        tape_strobe = 1'b1;
        sb.push_back(8'o052);
        tick();
        tape_strobe = 1'b0;
        repeat (3) tick();
        bus.io_bmb = 12'o6012;
        bus.iop_2  = 1'b1;
        #1;
        pop_expected();
        n_checks++; if (bus.db_l !== exp_db) begin n_fail++; $display("FAIL set_wins_read: got %o required %o", bus.db_l, exp_db); end
        tick();
        bus.iop_2 = 1'b0;
        n_checks++; if (flag !== 1'b1) begin n_fail++; $display("FAIL set_wins_flag: got %b required 1", flag); end
        tick();
        bus.iop_2 = 1'b1;
        tick();
        bus_idle();
        n_checks++; if (flag !== 1'b0) begin n_fail++; $display("FAIL set_wins_clear: got %b required 0", flag); end
    endtask

    task automatic test_reset_in_wait;
        for (int k = 0; k < 2; k++) begin
            bus.io_bmb = 12'o6014;
            bus.iop_4  = 1'b1;
            tick();
            bus_idle();
            tape_data   = 8'o123;
            tape_strobe = 1'b1;
            tick();
            tape_strobe = 1'b0;
            tick();
            if (k == 0) rst = 1'b0;
            else        bus.i_o_pwr_clr = 1'b1;
            tick();
            rst = 1'b1;
            bus.i_o_pwr_clr = 1'b0;
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr%0d_busy: got %b required 0", k, busy); end
            n_checks++; if (tape_req !== 1'b0) begin n_fail++; $display("FAIL clr%0d_req: got %b required 0", k, tape_req); end
            n_checks++; if (flag !== 1'b0) begin n_fail++; $display("FAIL clr%0d_flag: got %b required 0", k, flag); end
            tape_data   = 8'o321;
            tape_strobe = 1'b1;
            tick();
            tape_strobe = 1'b0;
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr%0d_late_strobe: got %b required 0", k, busy); end
            repeat (5) tick();
            n_checks++; if (flag !== 1'b0) begin n_fail++; $display("FAIL clr%0d_no_flag: got %b required 0", k, flag); end
            bus.io_bmb = 12'o6012;
            bus.iop_2  = 1'b1;
            #1;
            n_checks++; if (bus.db_l !== 12'o7777) begin n_fail++; $display("FAIL clr%0d_rb: got %o required 7777", k, bus.db_l); end
            tick();
            bus_idle();
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_skip();
        test_wrong_dev();
        test_read_and_fetch();
        test_busy_rfc();
        test_set_wins();
        test_reset_in_wait();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
